config_readback_tx: RTL and testbench
=====================================

# config_readback_tx

- Packet framer for the return direction of the host UART link. The host writes configuration bytes into config storage; this block reads those bytes back to the host.
- On `start` it reads `len` payload bytes from a synchronous-read memory port. It emits the packet `SYNC, LEN, payload[0..LEN-1], CHECKSUM` one byte at a time through the `uart_transmit` send/ready handshake.
- It sits between config storage (read port) and `uart_transmit` in the top level.

## Interface
- `MAX_LEN`, 32: largest payload in bytes.
- `ADDR_W`, 5: read-address width; 2^ADDR_W ≥ MAX_LEN.
- `SYNC`, 8'hA5: first byte of every packet.
- `clk` in 1: system clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `start` in 1: one-cycle request to send a packet. Sampled only in IDLE.
- `len` in 6: payload length. Sampled with `start`.
- `rd_addr` out ADDR_W: read address into config storage.
- `rd_data` in 8: read data, valid the cycle after `rd_addr` is presented.
- `tx_send` out 1: one-cycle send pulse to `uart_transmit`.
- `tx_data` out 8: byte to send. Held stable from the `tx_send` cycle until that byte completes.
- `tx_ready` in 1: `uart_transmit` ready. High = idle; low = shifting a byte.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the last byte (CHECKSUM) completes.

## Operation
- States: IDLE, FETCH, SEND, WAIT_ACK, WAIT_DONE, FINISH.
- Phase register: PH_SYNC, PH_LEN, PH_DATA, PH_CSUM.
- Byte index `idx`: 6 bits. Checksum accumulator `csum`: 8 bits.
- IDLE, on `start`:
  - latch `n = min(len, MAX_LEN)`;
  - clear `idx` and `csum`;
  - set phase PH_SYNC, `busy`=1, go to SEND.
- SEND:
  - if `tx_ready`=0, stay in SEND and do not pulse;
  - else drive `tx_data` with the phase byte, pulse `tx_send`=1, go to WAIT_ACK.
  - Phase bytes: PH_SYNC → SYNC; PH_LEN → `{2'b0,n}`; PH_DATA → the captured `rd_data`; PH_CSUM → `csum`.
- WAIT_ACK: wait for `tx_ready`=0, then go to WAIT_DONE. No timeout.
- WAIT_DONE: wait for `tx_ready`=1, then advance the phase:
  - PH_SYNC → PH_LEN.
  - PH_LEN → PH_DATA via FETCH if `n`>0; otherwise → PH_CSUM via SEND.
  - PH_DATA, `idx`+1 < `n`: increment `idx`, go to FETCH.
  - PH_DATA, `idx`+1 = `n`: go to PH_CSUM via SEND.
  - PH_CSUM → FINISH.
- FETCH: drive `rd_addr = idx[ADDR_W-1:0]`. Next cycle, capture `rd_data` into the byte register and go to SEND. FETCH lasts exactly 1 cycle.
- Checksum:
  - `csum += byte` (mod 256), applied when the LEN byte and each payload byte is accepted (the `tx_send` cycle).
  - SYNC is excluded.
  - Result: CHECKSUM = (n + Σpayload) mod 256.
- FINISH: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while `busy` is ignored; it is not queued.
- `len` > MAX_LEN is clamped to MAX_LEN, and the LEN byte carries the clamped value.
- `len`=0 produces the 3-byte packet A5, 00, 00.
- `rd_addr` holds its last value outside FETCH. Only the FETCH-cycle value is meaningful.

## Timing
- Reset values: `tx_send`=0, `tx_data`=0, `rd_addr`=0, `busy`=0, `done`=0; state IDLE, phase PH_SYNC, `idx`=0, `csum`=0.
- `rst` mid-packet aborts immediately:
  - next cycle is IDLE with all outputs at reset values;
  - no `done`; the partial packet is not resumed.
- Cycle 0 `start` accepted → cycle 1 `busy`=1, SEND. With `tx_ready`=1, `tx_send` pulses in cycle 1.
- `tx_send` is never high for two consecutive cycles.
- `tx_send` is never asserted while `tx_ready`=0.
- Per-byte overhead beyond the UART frame time:
  - 1 SEND + ≥1 WAIT_ACK + ≥1 WAIT_DONE cycles;
  - plus 2 extra cycles (FETCH, capture) for payload bytes.
- `done` is asserted 1 cycle after `tx_ready` returns high following the CHECKSUM byte. `busy` falls in the same cycle as `done`.
- A new `start` is accepted the cycle after `done`.

## Test plan
- `len`=3, memory[0..2]=01,02,03, UART model with 10-cycle busy:
  - bytes A5,03,01,02,03,09 in order;
  - exactly 6 `tx_send` pulses, then 1 `done` pulse;
  - `rd_addr` sequence 0,1,2.
- `len`=0 → A5,00,00, `done`; `rd_addr` is never in FETCH.
- `len`=40, memory[i]=i, MAX_LEN=32:
  - LEN byte = 20 (hex);
  - 32 payload bytes 00..1F;
  - checksum = (0x20 + 0x1F0) mod 256 = 0x10.
- Memory all FF, `len`=32: checksum = (0x20 + 32·0xFF) mod 256 = 0x00. Checks wrap-around.
- `tx_ready` held low 50 cycles at start:
  - no `tx_send` until it rises;
  - `start` pulsed again mid-packet is ignored (one packet only).
- `rst` asserted 2 cycles after the 3rd `tx_send`:
  - next cycle `busy`=0, `tx_send`=0, no `done`;
  - a following `start` with `len`=1 sends a clean A5,01,xx,checksum.

Source files
------------

// File: rtl/config_readback_tx_if.sv
// ============================================================================
// Module      : config_readback_tx_if
// Description : Bus bundle for config_readback_tx: request/status, the
//               config-storage read port and the uart_transmit handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface config_readback_tx_if #(
  parameter int ADDR_W = 5
) ();
  logic              start;
  logic [5:0]        len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tx_send;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic              done;

  // Framer side
  modport slave (
    input  start, len, rd_data, tx_ready,
    output rd_addr, tx_send, tx_data, busy, done
  );

  // Requester / storage / UART side
  modport master (
    output start, len, rd_data, tx_ready,
    input  rd_addr, tx_send, tx_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/config_readback_tx.sv
// ============================================================================
// Module      : config_readback_tx
// Description : Reads up to MAX_LEN configuration bytes from a synchronous
//               read port and frames them as SYNC, LEN, payload, CHECKSUM
//               through the uart_transmit send/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_readback_tx #(
  parameter int         MAX_LEN = 32,
  parameter int         ADDR_W  = 5,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  wire logic           clk,
  input  wire logic           rst,
  config_readback_tx_if.slave bus
);

  localparam logic [5:0] c_MAX_LEN = 6'(MAX_LEN);

  // CAPTURE is the cycle in which the synchronous memory returns the byte
  // addressed during FETCH.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_LEN  = 2'd1,
    PH_DATA = 2'd2,
    PH_CSUM = 2'd3
  } phase_t;

  state_t            r_state,   w_state_nx;
  phase_t            r_phase,   w_phase_nx;
  logic [5:0]        r_idx,     w_idx_nx;
  logic [5:0]        r_n,       w_n_nx;
  logic [7:0]        r_csum,    w_csum_nx;
  logic [7:0]        r_byte,    w_byte_nx;
  logic [7:0]        r_tx_data, w_tx_data_nx;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nx;
  logic [7:0]        w_phase_byte;
  logic [5:0]        w_idx_inc;
  logic              w_send;

  assign w_idx_inc = r_idx + 6'd1;
  assign w_send    = (r_state == S_SEND) && bus.tx_ready;

  // Byte belonging to the current packet phase
  always_comb begin
    w_phase_byte = r_csum;
    case (r_phase)
      PH_SYNC: w_phase_byte = SYNC;
      PH_LEN:  w_phase_byte = {2'b00, r_n};
      PH_DATA: w_phase_byte = r_byte;
      default: w_phase_byte = r_csum;
    endcase
  end

  // Next-state and datapath update logic
  always_comb begin
    w_state_nx   = r_state;
    w_phase_nx   = r_phase;
    w_idx_nx     = r_idx;
    w_n_nx       = r_n;
    w_csum_nx    = r_csum;
    w_byte_nx    = r_byte;
    w_tx_data_nx = r_tx_data;
    w_rd_addr_nx = r_rd_addr;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_n_nx     = (bus.len > c_MAX_LEN) ? c_MAX_LEN : bus.len;
          w_idx_nx   = 6'd0;
          w_csum_nx  = 8'd0;
          w_phase_nx = PH_SYNC;
          w_state_nx = S_SEND;
        end
      end
      S_FETCH: w_state_nx = S_CAPTURE;
      S_CAPTURE: begin
        w_byte_nx  = bus.rd_data;
        w_state_nx = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          w_tx_data_nx = w_phase_byte;
          // SYNC and the checksum itself are not summed
          if (r_phase == PH_LEN || r_phase == PH_DATA) begin
            w_csum_nx = r_csum + w_phase_byte;
          end
          w_state_nx = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!bus.tx_ready) w_state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.tx_ready) begin
          case (r_phase)
            PH_SYNC: begin
              w_phase_nx = PH_LEN;
              w_state_nx = S_SEND;
            end
            PH_LEN: begin
              if (r_n != 6'd0) begin
                w_phase_nx   = PH_DATA;
                w_rd_addr_nx = r_idx[ADDR_W-1:0];
                w_state_nx   = S_FETCH;
              end else begin
                w_phase_nx = PH_CSUM;
                w_state_nx = S_SEND;
              end
            end
            PH_DATA: begin
              if (w_idx_inc < r_n) begin
                w_idx_nx     = w_idx_inc;
                w_rd_addr_nx = w_idx_inc[ADDR_W-1:0];
                w_state_nx   = S_FETCH;
              end else begin
                w_phase_nx = PH_CSUM;
                w_state_nx = S_SEND;
              end
            end
            default: w_state_nx = S_FINISH;
          endcase
        end
      end
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= PH_SYNC;
      r_idx     <= 6'd0;
      r_n       <= 6'd0;
      r_csum    <= 8'd0;
      r_byte    <= 8'd0;
      r_tx_data <= 8'd0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_idx     <= w_idx_nx;
      r_n       <= w_n_nx;
      r_csum    <= w_csum_nx;
      r_byte    <= w_byte_nx;
      r_tx_data <= w_tx_data_nx;
      r_rd_addr <= w_rd_addr_nx;
    end
  end

  // The byte is presented combinationally in the send cycle, then held
  // from r_tx_data until the UART finishes shifting it.
  assign bus.tx_send = w_send;
  assign bus.tx_data = (r_state == S_SEND) ? w_phase_byte : r_tx_data;
  assign bus.rd_addr = r_rd_addr;
  assign bus.busy    = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign bus.done    = (r_state == S_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_config_readback_tx.sv
// ============================================================================
// Module      : tb_config_readback_tx
// Description : Scoreboard bench for config_readback_tx with a sync-read
//               memory model and a uart_transmit ready/busy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_readback_tx;

  typedef struct {
    logic [7:0] b;
    bit         pay;
    int         addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  config_readback_tx_if #(.ADDR_W(5)) bus ();

  config_readback_tx #(.MAX_LEN(32), .ADDR_W(5), .SYNC(8'hA5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fails  = 0;
  int         sends    = 0;
  int         dones    = 0;
  logic [7:0] last_byte = 8'h00;
  exp_t       q[$];

  // Sync-read config storage
  logic [7:0] mem [0:31];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  // UART model: ready drops the cycle after a send and stays low a while
  int   ucnt = 0;
  logic tx_hold = 1'b0;
  bit   uart_rand = 1'b0;
  always @(posedge clk) begin
    if (bus.tx_send) ucnt <= uart_rand ? int'($urandom_range(3, 12)) : 10;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign bus.tx_ready = (ucnt == 0) && !tx_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the whole packet computed from the packet rules
  task automatic push_packet(input int l);
    int n;
    int s;
    n = (l > 32) ? 32 : l;
    s = n;
    q.push_back('{8'hA5, 1'b0, 0});
    q.push_back('{8'(n), 1'b0, 0});
    for (int i = 0; i < n; i++) begin
      q.push_back('{mem[i], 1'b1, i});
      s += mem[i];
    end
    q.push_back('{8'(s % 256), 1'b0, 0});
  endtask

  // Monitor: pops the scoreboard on every send and checks handshake rules
  logic       prev_send = 1'b0;
  logic       inflight  = 1'b0;
  logic       seen_low  = 1'b0;
  logic [7:0] fly_byte  = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.tx_send) begin
        sends++;
        last_byte = bus.tx_data;
        chk("send_while_not_ready", bus.tx_ready, 1'b1);
        chk("send_back_to_back", prev_send, 1'b0);
        if (q.size() == 0) begin
          chk("unexpected_send", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tx_byte", bus.tx_data, e.b);
          if (e.pay) chk("rd_addr_for_payload", bus.rd_addr, e.addr);
        end
        inflight = 1'b1;
        seen_low = 1'b0;
        fly_byte = bus.tx_data;
      end else if (inflight) begin
        chk("tx_data_stable", bus.tx_data, fly_byte);
        if (!bus.tx_ready) seen_low = 1'b1;
        else if (seen_low) inflight = 1'b0;
      end
      if (bus.done) begin
        dones++;
        chk("done_all_bytes_sent", q.size(), 0);
        chk("busy_low_with_done", bus.busy, 1'b0);
      end
    end else begin
      inflight = 1'b0;
    end
    prev_send = bus.tx_send;
  end

  task automatic issue(input int l);
    push_packet(l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 6'(l);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    chk("first_send_cycle1", bus.tx_send, bus.tx_ready);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = dones;
    k  = 0;
    while (dones == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", (dones != d0), 1'b1);
  endtask

  task automatic wait_sends(input int cnt, output int got);
    int k;
    got = bus.tx_send ? 1 : 0;
    k   = 0;
    while (got < cnt && k < 2000) begin
      @(negedge clk);
      k++;
      if (bus.tx_send) got++;
    end
  endtask

  initial begin
    int s0;
    int got;
    int d0;
    logic [4:0] a0;
    int l;
    bus.start = 1'b0;
    bus.len   = 6'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_tx_send", bus.tx_send, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_rd_addr", bus.rd_addr, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    // len=3, payload 01 02 03
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    s0 = sends;
    issue(3);
    wait_done(2000);
    chk("len3_send_count", sends - s0, 6);
    chk("len3_checksum", last_byte, 8'h09);
    chk("len3_last_rd_addr", bus.rd_addr, 5'd2);

    // len=0: no fetch, rd_addr untouched
    a0 = bus.rd_addr;
    s0 = sends;
    issue(0);
    wait_done(2000);
    chk("len0_send_count", sends - s0, 3);
    chk("len0_checksum", last_byte, 8'h00);
    chk("len0_rd_addr_held", bus.rd_addr, a0);

    // len=40 clamps to 32, memory[i]=i
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    s0 = sends;
    issue(40);
    wait_done(4000);
    chk("clamp_send_count", sends - s0, 35);
    chk("clamp_checksum", last_byte, 8'h10);

    // All FF, checksum wraps to 00
    for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
    issue(32);
    wait_done(4000);
    chk("wrap_checksum", last_byte, 8'h00);

    // tx_ready held low at start; a second start mid-packet is ignored
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    tx_hold = 1'b1;
    s0 = sends;
    issue(4);
    repeat (50) @(negedge clk);
    chk("hold_no_send", sends - s0, 0);
    tx_hold = 1'b0;
    wait_sends(3, got);
    chk("hold_sends_resume", got, 3);
    bus.start = 1'b1;
    bus.len   = 6'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2000);
    chk("one_packet_only", sends - s0, 7);
    repeat (60) @(negedge clk);
    chk("no_queued_packet", sends - s0, 7);
    chk("idle_after_ignored_start", bus.busy, 1'b0);

    // Reset two cycles after the third send aborts the packet
    uart_rand = 1'b1;
    issue(5);
    wait_sends(3, got);
    chk("abort_third_send", got, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    d0 = dones;
    @(negedge clk);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_tx_send", bus.tx_send, 1'b0);
    chk("abort_tx_data", bus.tx_data, 8'h00);
    chk("abort_rd_addr", bus.rd_addr, 5'd0);
    rst = 1'b0;
    q.delete();
    repeat (20) @(negedge clk);
    chk("abort_no_done", dones - d0, 0);
    s0 = sends;
    issue(1);
    wait_done(2000);
    chk("after_abort_send_count", sends - s0, 4);

    // Randomized packets
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      l = int'($urandom_range(0, 40));
      issue(l);
      wait_done(5000);
    end
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
